spi_txn_sequencer: RTL and testbench

Sequences complete SPI flash-style read transactions over the byte-level SPI master. Each transaction is one command byte, then 0–3 address bytes MSB-first, then i_rd_len received bytes. The block drives the master's send/receive strobes and byte inputs, and paces itself on the master's bit-counter status outputs. It sits between the ILA control logic (requester) and the SPI master, all in the i_sclk domain.

---
 rtl/spi_txn_sequencer.sv | 114 +++++++++++
 tb/tb_spi_txn_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: issues command/address/read SPI transactions over a byte-level SPI master
module spi_txn_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             i_sclk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [7:0]       i_cmd,
    input  logic [23:0]      i_addr,
    input  logic [1:0]       i_addr_bytes,
    input  logic [LEN_W-1:0] i_rd_len,
    output logic             o_busy,
    output logic             o_rd_valid,
    output logic [7:0]       o_rd_data,
    output logic             o_done,
    output logic             o_spi_send,
    output logic [7:0]       o_spi_send_byte,
    output logic             o_spi_receive,
    input  logic [7:0]       i_spi_receive_byte,
    input  logic             i_spi_period,
    input  logic             i_spi_cnt_end
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, DRAIN, DONE} state_t;
    state_t           r_state;
    logic [23:0]      r_addr;
    logic [1:0]       r_acnt;
    logic [LEN_W-1:0] r_rem;
    logic             r_armed;
    logic             r_drain;
    logic [1:0]       w_next_n;
    logic [7:0]       w_abyte;
    // Address bytes still owed after the byte now being loaded, and the next one to present
    always_comb begin
        w_next_n = (r_state == CMD) ? r_acnt : r_acnt - 2'd1;
        w_abyte  = (w_next_n == 2'd3) ? r_addr[23:16] :
                   (w_next_n == 2'd2) ? r_addr[15:8] : r_addr[7:0];
    end
    // Transaction sequencer; every output is registered here
    always_ff @(posedge i_sclk) begin
        if (!i_reset) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_acnt          <= '0;
            r_rem           <= '0;
            r_armed         <= 1'b0;
            r_drain         <= 1'b0;
            o_busy          <= 1'b0;
            o_rd_valid      <= 1'b0;
            o_rd_data       <= '0;
            o_done          <= 1'b0;
            o_spi_send      <= 1'b0;
            o_spi_send_byte <= '0;
            o_spi_receive   <= 1'b0;
        end else begin
            o_rd_valid <= 1'b0;
            o_done     <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_addr          <= i_addr;
                    r_acnt          <= i_addr_bytes;
                    r_rem           <= i_rd_len;
                    r_armed         <= 1'b0;
                    r_drain         <= 1'b0;
                    o_busy          <= 1'b1;
                    o_spi_send      <= 1'b1;
                    o_spi_send_byte <= i_cmd;
                    r_state         <= CMD;
                end
                CMD, ADDR: if (i_spi_period) begin
                    r_acnt <= w_next_n;
                    if (w_next_n != 2'd0) begin
                        o_spi_send_byte <= w_abyte;
                        r_state         <= ADDR;
                    end else begin
                        o_spi_send    <= 1'b0;
                        o_spi_receive <= (r_rem != '0);
                        r_state       <= (r_rem != '0) ? READ : DRAIN;
                    end
                end
                READ: begin
                    if (i_spi_period) begin
                        r_armed <= 1'b1;
                        if (r_rem == LEN_W'(1)) o_spi_receive <= 1'b0;
                    end
                    if (i_spi_cnt_end && r_armed) begin
                        o_rd_data  <= i_spi_receive_byte;
                        o_rd_valid <= 1'b1;
                        r_armed    <= 1'b0;
                        r_rem      <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) begin
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DRAIN: begin
                    r_drain <= i_spi_cnt_end;
                    if (i_spi_cnt_end && r_drain) begin
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    o_spi_send    <= 1'b0;
                    o_spi_receive <= 1'b0;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb_spi_txn_sequencer: directed checks of the SPI transaction sequencer against a byte-level master model
module tb_spi_txn_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_cmd = '0;
    logic [23:0] i_addr = '0;
    logic [1:0]  i_addr_bytes = '0;
    logic [7:0]  i_rd_len = '0;
    logic        o_busy, o_rd_valid, o_done, o_spi_send, o_spi_receive;
    logic [7:0]  o_rd_data, o_spi_send_byte;
    logic [7:0]  spi_rx_byte = '0;
    logic [2:0]  m_cnt = '0;
    logic        m_rx = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  miso [0:3];
    logic [7:0]  mosi [0:7];
    int          mosi_t [0:7];
    int          mosi_n = 0;
    logic [1:0]  miso_i = '0;
    logic [7:0]  rx [0:7];
    int          rx_n = 0;
    int          done_n = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    spi_txn_sequencer #(.LEN_W(8)) dut (
        .i_sclk(clk), .i_reset(rst), .i_start(i_start), .i_cmd(i_cmd), .i_addr(i_addr),
        .i_addr_bytes(i_addr_bytes), .i_rd_len(i_rd_len), .o_busy(o_busy),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_done(o_done),
        .o_spi_send(o_spi_send), .o_spi_send_byte(o_spi_send_byte),
        .o_spi_receive(o_spi_receive), .i_spi_receive_byte(spi_rx_byte),
        .i_spi_period(m_cnt == 3'd1), .i_spi_cnt_end(m_cnt == 3'd0)
    );

    always #5 clk = ~clk;

    // Byte-level master: 8 clocks per byte, back-to-back while a request stays high
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            m_cnt <= '0;
            m_rx  <= 1'b0;
        end else if (m_cnt == 3'd0) begin
            if (o_spi_send || o_spi_receive) begin
                m_cnt <= 3'd1;
                m_rx  <= !o_spi_send;
                if (o_spi_send && mosi_n < 8) begin
                    mosi[mosi_n]   <= o_spi_send_byte;
                    mosi_t[mosi_n] <= cyc;
                    mosi_n         <= mosi_n + 1;
                end
            end
        end else begin
            m_cnt <= m_cnt + 3'd1;
            if (m_cnt == 3'd7 && m_rx) begin
                spi_rx_byte <= miso[miso_i];
                miso_i      <= miso_i + 2'd1;
            end
        end
        if (clr) begin
            mosi_n <= 0;
            miso_i <= '0;
        end
    end

    // Collect received bytes and done pulses
    always @(posedge clk) begin
        if (clr) begin
            rx_n   <= 0;
            done_n <= 0;
        end else begin
            if (o_rd_valid && rx_n < 8) begin
                rx[rx_n] <= o_rd_data;
                rx_n     <= rx_n + 1;
            end
            if (o_done) done_n <= done_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] c, input logic [23:0] a, input logic [1:0] ab, input logic [7:0] len);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        i_cmd = c; i_addr = a; i_addr_bytes = ab; i_rd_len = len; i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400 && done_n == 0; i++) @(negedge clk);
        check({tag, "_done"}, done_n, 1);
        repeat (12) @(negedge clk);
        check({tag, "_done_once"}, done_n, 1);
        check({tag, "_busy_low"}, o_busy, 0);
    endtask

    initial begin
        miso[0] = 8'hA5; miso[1] = 8'h3C; miso[2] = 8'h00; miso[3] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("reset_outs", {o_busy, o_done, o_rd_valid, o_spi_send, o_spi_receive, o_spi_send_byte, o_rd_data}, 0);

        start(8'h03, 24'h123456, 2'd3, 8'd2);
        check("t1_busy", o_busy, 1);
        wait_done("t1");
        check("t1_mosi_n", mosi_n, 4);
        check("t1_mosi", {mosi[0], mosi[1], mosi[2], mosi[3]}, 32'h03123456);
        check("t1_gapless", mosi_t[3] - mosi_t[0], 24);
        check("t1_rx_n", rx_n, 2);
        check("t1_rx", {rx[0], rx[1]}, 16'hA53C);

        miso[0] = 8'hEF; miso[1] = 8'h40; miso[2] = 8'h18;
        start(8'h9F, 24'h000000, 2'd0, 8'd3);
        wait_done("t2");
        check("t2_mosi_n", mosi_n, 1);
        check("t2_mosi", mosi[0], 8'h9F);
        check("t2_rx_n", rx_n, 3);
        check("t2_rx", {rx[0], rx[1], rx[2]}, 24'hEF4018);

        start(8'h06, 24'h000000, 2'd0, 8'd0);
        wait_done("t3");
        check("t3_mosi_n", mosi_n, 1);
        check("t3_mosi", mosi[0], 8'h06);
        check("t3_rx_n", rx_n, 0);

        miso[0] = 8'h5A;
        start(8'h03, 24'hAABBCC, 2'd2, 8'd1);
        repeat (5) @(negedge clk);
        i_cmd = 8'h55; i_addr = 24'h111111; i_addr_bytes = 2'd3; i_rd_len = 8'd4; i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        wait_done("t4");
        repeat (20) @(negedge clk);
        check("t4_mosi_n", mosi_n, 3);
        check("t4_mosi", {mosi[0], mosi[1], mosi[2]}, 24'h03BBCC);
        check("t4_rx", {rx_n[7:0], rx[0]}, 16'h015A);

        miso[0] = 8'hC3;
        start(8'h0B, 24'h0000FF, 2'd1, 8'd1);
        wait_done("t5");
        check("t5_mosi_n", mosi_n, 2);
        check("t5_mosi", {mosi[0], mosi[1]}, 16'h0BFF);
        check("t5_rx", {rx_n[7:0], rx[0]}, 16'h01C3);

        start(8'h03, 24'h000000, 2'd0, 8'd3);
        for (int i = 0; i < 100 && !o_spi_receive; i++) @(negedge clk);
        check("t6_in_read", o_spi_receive, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("t6_reset_outs", {o_busy, o_done, o_rd_valid, o_spi_send, o_spi_receive}, 0);
        repeat (30) @(negedge clk);
        check("t6_no_done", done_n, 0);
        check("t6_no_rx", rx_n, 0);
        check("t6_idle", {o_busy, o_spi_send, o_spi_receive}, 0);

        miso[0] = 8'h77;
        start(8'h9F, 24'h000000, 2'd0, 8'd1);
        wait_done("t7");
        check("t7_mosi", {mosi_n[7:0], mosi[0]}, 16'h019F);
        check("t7_rx", {rx_n[7:0], rx[0]}, 16'h0177);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
